idli_serial_alu: RTL

Parametrised bit-serial ALU and comparator for the idli core. It consumes LHS/RHS operands one SLICE_W-bit slice per cycle, LSB slice first, and produces result slices one cycle later. The carry is held in a flop across slices, and a comparison verdict plus carry/overflow flags are delivered at the end of the word. It sits in the execute path between the operand source mux and the destination writeback. It generalises the fixed 4b x 4 slicing to any SLICE_W/DATA_W pair.

---
 rtl/idli_pkg.sv | 34 +++
 rtl/idli_serial_cmp.sv | 66 ++++++
 rtl/idli_serial_alu.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/idli_pkg.sv
// Shared idli core types: ALU/compare opcodes, serial slice FSM states and defaults.
package idli_pkg;

    localparam int unsigned SLICE_W_DFLT = 4;
    localparam int unsigned DATA_W_DFLT  = 16;

    typedef enum logic [1:0] {
        ALU_OP_ADD = 2'd0,
        ALU_OP_AND = 2'd1,
        ALU_OP_OR  = 2'd2,
        ALU_OP_XOR = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        CMP_OP_EQ = 2'd0,
        CMP_OP_NE = 2'd1,
        CMP_OP_LT = 2'd2,
        CMP_OP_GE = 2'd3
    } cmp_op_t;

    typedef enum logic {
        SLICE_IDLE = 1'b0,
        SLICE_RUN  = 1'b1
    } slice_state_t;

    // Operation controls captured when an operation is accepted.
    typedef struct packed {
        alu_op_t alu_op;
        logic    rhs_inv;
        cmp_op_t cmp_op;
        logic    cmp_sign;
    } slice_ctrl_t;

endpackage

// File: rtl/idli_serial_cmp.sv
// Slice-serial comparator: accumulates equality and less-than from LSB slice upward,
// treating the MSB slice as signed when requested; verdict registered on the last slice.
module idli_serial_cmp
    import idli_pkg::*;
#(
    parameter int unsigned SLICE_W = SLICE_W_DFLT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_vld,
    input  logic               i_first,
    input  logic               i_last,
    input  cmp_op_t            i_cmp_op,
    input  logic               i_cmp_sign,
    input  logic [SLICE_W-1:0] i_lhs,
    input  logic [SLICE_W-1:0] i_rhs,
    output logic               o_cmp
);

    logic eq_q, eq_d;
    logic lt_q, lt_d;
    logic cmp_q, cmp_d;
    logic slice_eq;
    logic slice_lt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            eq_q  <= 1'b0;
            lt_q  <= 1'b0;
            cmp_q <= 1'b0;
        end else begin
            eq_q  <= eq_d;
            lt_q  <= lt_d;
            cmp_q <= cmp_d;
        end
    end

    // Higher slices override lower ones unless they are equal.
    always_comb begin
        eq_d     = eq_q;
        lt_d     = lt_q;
        cmp_d    = 1'b0;
        slice_eq = (i_lhs == i_rhs);
        if (i_last && i_cmp_sign) begin
            slice_lt = ($signed(i_lhs) < $signed(i_rhs));
        end else begin
            slice_lt = (i_lhs < i_rhs);
        end
        if (i_vld) begin
            eq_d = slice_eq & (i_first | eq_q);
            lt_d = slice_lt | (slice_eq & ~i_first & lt_q);
            if (i_last) begin
                case (i_cmp_op)
                    CMP_OP_EQ: cmp_d = eq_d;
                    CMP_OP_NE: cmp_d = ~eq_d;
                    CMP_OP_LT: cmp_d = lt_d;
                    CMP_OP_GE: cmp_d = ~lt_d;
                    default:   cmp_d = 1'b0;
                endcase
            end
        end
    end

    assign o_cmp = cmp_q;

endmodule

// File: rtl/idli_serial_alu.sv
// Bit-serial ALU/comparator: one SLICE_W slice per cycle, LSB first, result one cycle later,
// with compare verdict and carry/overflow flags pulsed alongside the final result slice.
module idli_serial_alu
    import idli_pkg::*;
#(
    parameter int unsigned SLICE_W = SLICE_W_DFLT,
    parameter int unsigned DATA_W  = DATA_W_DFLT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  alu_op_t            i_alu_op,
    input  logic               i_alu_rhs_inv,
    input  cmp_op_t            i_cmp_op,
    input  logic               i_cmp_sign,
    input  logic [SLICE_W-1:0] i_lhs,
    input  logic [SLICE_W-1:0] i_rhs,
    output logic               o_busy,
    output logic [SLICE_W-1:0] o_res,
    output logic               o_res_vld,
    output logic               o_cmp,
    output logic               o_cmp_vld,
    output logic               o_cout,
    output logic               o_ovf
);

    localparam int unsigned NUM_SLICES = DATA_W / SLICE_W;
    localparam int unsigned CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int unsigned SUM_W      = SLICE_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SLICES - 1);

    if (((DATA_W % SLICE_W) != 0) || ((DATA_W / SLICE_W) < 2)) begin : g_param_check
        $error("idli_serial_alu: DATA_W must be a multiple of SLICE_W with at least two slices");
    end

    slice_state_t       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    slice_ctrl_t        ctrl_q, ctrl_d;
    logic [SLICE_W-1:0] res_q, res_d;
    logic               res_vld_q, res_vld_d;
    logic               cmp_vld_q, cmp_vld_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    slice_ctrl_t        ctrl_in;
    slice_ctrl_t        ctrl_cur;
    logic               accept;
    logic               proc;
    logic               last;
    logic               carry_in;
    logic               c_into_msb;
    logic [SLICE_W-1:0] rhs_eff;
    logic [SLICE_W-1:0] slice_res;
    logic [SUM_W-1:0]   sum;

    assign ctrl_in  = '{alu_op: i_alu_op, rhs_inv: i_alu_rhs_inv,
                        cmp_op: i_cmp_op, cmp_sign: i_cmp_sign};
    assign accept   = (state_q == SLICE_IDLE) && i_start;
    assign proc     = accept || (state_q == SLICE_RUN);
    assign last     = (state_q == SLICE_RUN) && (cnt_q == LAST_IDX);
    // Slice 0 runs in the accept cycle, before the controls are latched.
    assign ctrl_cur = accept ? ctrl_in : ctrl_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= SLICE_IDLE;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            ctrl_q    <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
            cmp_vld_q <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            ctrl_q    <= ctrl_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
            cmp_vld_q <= cmp_vld_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SLICE_IDLE: begin
                if (i_start) begin
                    state_d = SLICE_RUN;
                    cnt_d   = CNT_W'(1);
                end
            end
            SLICE_RUN: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = SLICE_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = SLICE_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        carry_d    = carry_q;
        res_d      = '0;
        res_vld_d  = 1'b0;
        cmp_vld_d  = 1'b0;
        cout_d     = 1'b0;
        ovf_d      = 1'b0;
        rhs_eff    = ctrl_cur.rhs_inv ? ~i_rhs : i_rhs;
        carry_in   = accept ? i_alu_rhs_inv : carry_q;
        sum        = SUM_W'(i_lhs) + SUM_W'(rhs_eff) + SUM_W'(carry_in);
        c_into_msb = i_lhs[SLICE_W-1] ^ rhs_eff[SLICE_W-1] ^ sum[SLICE_W-1];
        case (ctrl_cur.alu_op)
            ALU_OP_ADD: slice_res = sum[SLICE_W-1:0];
            ALU_OP_AND: slice_res = i_lhs & rhs_eff;
            ALU_OP_OR:  slice_res = i_lhs | rhs_eff;
            ALU_OP_XOR: slice_res = i_lhs ^ rhs_eff;
            default:    slice_res = '0;
        endcase
        if (accept) begin
            ctrl_d = ctrl_in;
        end
        if (proc) begin
            res_d     = slice_res;
            res_vld_d = 1'b1;
            if (ctrl_cur.alu_op == ALU_OP_ADD) begin
                carry_d = sum[SLICE_W];
            end
        end
        if (last) begin
            cmp_vld_d = 1'b1;
            if (ctrl_cur.alu_op == ALU_OP_ADD) begin
                cout_d = sum[SLICE_W];
                ovf_d  = c_into_msb ^ sum[SLICE_W];
            end
        end
    end

    idli_serial_cmp #(
        .SLICE_W (SLICE_W)
    ) u_cmp (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_vld      (proc),
        .i_first    (accept),
        .i_last     (last),
        .i_cmp_op   (ctrl_cur.cmp_op),
        .i_cmp_sign (ctrl_cur.cmp_sign),
        .i_lhs      (i_lhs),
        .i_rhs      (i_rhs),
        .o_cmp      (o_cmp)
    );

    assign o_busy    = (state_q == SLICE_RUN);
    assign o_res     = res_q;
    assign o_res_vld = res_vld_q;
    assign o_cmp_vld = cmp_vld_q;
    assign o_cout    = cout_q;
    assign o_ovf     = ovf_q;

endmodule
